// File: rtl/mic_frontend_pkg.sv
// Shared types and constants for the microphone conditioning front end.
package mic_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } mf_state_t;

  localparam int DC_SHIFT = 8;
  localparam logic [7:0] MID_SCALE = 8'h80;

endpackage

// File: rtl/mic_frontend_tick_gen.sv
// Sample-rate divider: one tick every div+1 cycles while run is high.
module tick_gen
  import mic_frontend_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  // A count already past a newly lowered div keeps climbing and wraps.
  assign tick = run && (count == div);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mic_frontend.sv
// Mic ADC pacing, DC removal, gain/saturation and delay-line strobes.
module mic_frontend
  import mic_frontend_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 9,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [A_WIDTH-1:0]   offset,
  input  logic [2:0]           gain,
  output logic [D_WIDTH-1:0]   mic_signal,
  output logic                 en,
  output logic                 wr,
  output logic                 rd,
  output logic                 clip
);

  localparam int AW   = ADC_WIDTH + DC_SHIFT;
  localparam int YW   = ADC_WIDTH + 1;
  localparam int SW   = YW + 7;
  localparam int DROP = ADC_WIDTH - D_WIDTH;
  localparam logic [D_WIDTH-1:0]   MID  = D_WIDTH'(MID_SCALE);
  localparam logic signed [SW-1:0] ZMAX = SW'((1 << (D_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] ZMIN = ~ZMAX;

  mf_state_t state, state_nxt;
  logic tick, active, v1, fill_done, sat_hi, sat_lo;
  logic [A_WIDTH-1:0] off_q, fill_cnt;
  logic [A_WIDTH:0] fill_sum;
  logic signed [ADC_WIDTH-1:0] x;
  logic signed [AW-1:0] x_ext, mean, acc, acc_nxt;
  logic signed [YW-1:0] y, y_nxt;
  logic signed [SW-1:0] shifted, z;
  logic [D_WIDTH-1:0] sat_val, mic_nxt;

  tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state != IDLE),
    .div  (div),
    .tick (tick)
  );

  // Dropping enable kills the pipeline on the same edge as the IDLE transition.
  assign active = (state != IDLE) && enable;

  always_comb begin
    x       = $signed({~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]});
    x_ext   = {{DC_SHIFT{x[ADC_WIDTH-1]}}, x};
    mean    = acc >>> DC_SHIFT;
    acc_nxt = acc + x_ext - mean;
    y_nxt   = {x[ADC_WIDTH-1], x} - mean[YW-1:0];
    shifted = {{7{y[YW-1]}}, y} <<< gain;
    z       = shifted >>> DROP;
    sat_hi  = z > ZMAX;
    sat_lo  = z < ZMIN;
    if (sat_hi) begin
      sat_val = ZMAX[D_WIDTH-1:0];
    end else if (sat_lo) begin
      sat_val = ZMIN[D_WIDTH-1:0];
    end else begin
      sat_val = z[D_WIDTH-1:0];
    end
    mic_nxt = {~sat_val[D_WIDTH-1], sat_val[D_WIDTH-2:0]};
  end

  // Strobes issued so far, including one on the output this cycle; once that
  // reaches off_q every later strobe reads locations already written.
  always_comb begin
    fill_sum  = {1'b0, fill_cnt} + {{A_WIDTH{1'b0}}, en};
    fill_done = (state == RUN) || (fill_sum >= {1'b0, off_q});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FILL;
      FILL:    if (!enable) state_nxt = IDLE;
               else if (fill_done) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= '0;
      fill_cnt   <= '0;
      acc        <= '0;
      y          <= '0;
      v1         <= 1'b0;
      mic_signal <= MID;
      en         <= 1'b0;
      wr         <= 1'b0;
      rd         <= 1'b0;
      clip       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        off_q    <= offset;
        fill_cnt <= '0;
      end else if (state == FILL && en) begin
        fill_cnt <= fill_cnt + A_WIDTH'(1);
      end
      if (!active) begin
        acc        <= '0;
        v1         <= 1'b0;
        mic_signal <= MID;
        en         <= 1'b0;
        wr         <= 1'b0;
        rd         <= 1'b0;
        clip       <= 1'b0;
      end else begin
        v1 <= tick;
        if (tick) begin
          acc <= acc_nxt;
          y   <= y_nxt;
        end
        en <= v1;
        wr <= v1;
        rd <= v1 && fill_done;
        if (v1) begin
          mic_signal <= mic_nxt;
          clip       <= clip | sat_hi | sat_lo;
        end
      end
    end
  end

endmodule

// File: doc/mic_frontend.md
# mic_frontend

Upstream conditioning stage for the signal-delay path. It paces the raw microphone ADC at a programmable sample rate, removes DC with a leaky integrator, applies a power-of-two gain with saturation, and emits 8-bit offset-binary samples. It also generates the `en`/`wr`/`rd` strobes for the delay stage, so that stage never reads RAM locations that have not yet been written since arming.

## Interface
- `ADC_WIDTH`, 12: raw ADC sample width, offset-binary.
- `D_WIDTH`, 8: output sample width, offset-binary.
- `A_WIDTH`, 9: delay-line address width; matches the delay stage's `offset`.
- `DIV_WIDTH`, 16: sample-rate divider width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; low forces IDLE.
- `div`  in  DIV_WIDTH  sample period is `div`+1 clk cycles.
- `adc_data`  in  ADC_WIDTH  raw mic sample, offset-binary.
- `offset`  in  A_WIDTH  delay length in samples; latched on arming.
- `gain`  in  3  left shift 0..7 applied after DC removal.
- `mic_signal`  out  D_WIDTH  conditioned sample, registered.
- `en`  out  1  one-cycle strobe; `mic_signal` is new this cycle.
- `wr`  out  1  delay-RAM write strobe.
- `rd`  out  1  delay-RAM read strobe.
- `clip`  out  1  sticky saturation flag.

## Operation
- **FSM states:** IDLE, FILL, RUN.
- **Reset:** IDLE. Outputs: `mic_signal`=0x80, `en`=`wr`=`rd`=`clip`=0. Internal: `acc`=0, tick count=0, fill count=0.
- **IDLE:**
  - Tick counter held at 0, `acc` cleared, `mic_signal`=0x80, `clip` cleared.
  - `enable`=1 moves to FILL next cycle and latches `offset` into `off_q`.
- **Tick generation:** in FILL/RUN, count 0..`div`; tick when count==`div`, then count returns to 0. `div`=0 gives a tick every cycle.
- **Stage 1 (on tick):**
  - x = `adc_data` with MSB inverted, read as signed ADC_WIDTH.
  - mean = `acc` >>> 8; `acc` is signed, ADC_WIDTH+8 bits.
  - `acc` <= `acc` + x − mean.
  - y = x − mean, signed ADC_WIDTH+1, registered.
- **Stage 2:**
  - z = (y <<< `gain`) >>> (ADC_WIDTH−D_WIDTH), computed with no intermediate truncation.
  - Saturate z to [−128, 127]; `mic_signal` = saturated z with MSB inverted.
  - `en` pulses for one cycle. `clip` is set if saturation occurred and stays set until IDLE or `rst`.
- **FILL:**
  - Each `en` strobe has `wr`=1, `rd`=0, and increments the fill count.
  - On the strobe where the fill count reaches `off_q`, move to RUN next cycle.
  - `off_q`=0 enters RUN the cycle after entering FILL.
- **RUN:** each strobe has `en`=`wr`=`rd`=1.
- **Strobe outputs:** `wr` and `rd` are only ever high together with `en`.
- **`enable` low in any state:** IDLE next cycle. A sample in flight in the pipeline is discarded, so no `en` follows.
- **`offset` changes** in FILL/RUN are ignored until the next arming.
- **`div` changes** take effect at the next count comparison. If count > new `div`, the counter runs on, wraps at 2^DIV_WIDTH−1 to 0, and then reaches `div`; no hang.

## Timing
- **Latency:** a tick in cycle T samples `adc_data`; `mic_signal`/`en`/`wr`/`rd` are valid in cycle T+2.
- **Strobe pattern:** `en` high exactly one cycle per sample period; period `div`+1 cycles.
- **First sample:** the first tick occurs `div` cycles after FILL entry, counting the entry cycle as count 0.
- **FILL→RUN:** the transition happens the cycle after the `off_q`-th strobe. The (`off_q`+1)-th strobe is the first with `rd`=1.
- **Reset precedence:** `rst` overrides everything in the same edge, mid-pipeline included.

## Structure
- **Package `mic_frontend_pkg`:**
  - State enum `mf_state_t` {IDLE, FILL, RUN}.
  - Constant `DC_SHIFT`=8.
  - Output mid-scale constant 0x80.
- **Sub-module `tick_gen`:** the divider counter. Inputs `clk`, `rst`, `run`, `div`; output `tick`.
- **Top level:** FSM, DC blocker, gain/saturate pipeline and fill counter stay in `mic_frontend`.

## Test plan
- **Reset and idle:** `rst` high, then `enable`=0 for 20 cycles → `mic_signal`=0x80; `en`, `wr`, `rd`, `clip` all 0.
- **Pacing:** `div`=3, `offset`=0, `enable`=1 → `en` every 4 cycles; `rd`=1 on every strobe; constant `adc_data`=0x800 gives `mic_signal`=0x80.
- **DC step:** `div`=0, `gain`=0, `adc_data` steps to 0x900 (x=256) → first output 0x90, then outputs decay monotonically toward 0x80; `clip` stays 0.
- **Saturation:** same step with `gain`=3 → first output 0xFF, `clip`=1 and sticky. `enable` low clears `clip`.
- **Fill:** `offset`=5, `div`=1 → strobes 1–5 have `wr`=1/`rd`=0, strobe 6 onward has `wr`=`rd`=1. Changing `offset` to 2 in RUN has no effect.
- **Abort:** drop `enable` one cycle after a tick → no `en` follows; state is IDLE and `mic_signal`=0x80 next cycle. Re-arming restarts FILL with the fill count at 0.
